// File: rtl/rom_pkg.sv
// Shared definitions for the boot ROM slave: RISC-V encodings used by the
// built-in boot stub, the stub word builder, and error-cause codes.
package rom_pkg;

    localparam logic [6:0] RV_OPC_LUI  = 7'h37;
    localparam logic [6:0] RV_OPC_JALR = 7'h67;
    localparam logic [4:0] REG_X2      = 5'd2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_WRITE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_RANGE    = 2'd3
    } err_cause_e;

    // Word 0: lui x2, target[31:12]; word 1: jalr x0, 0(x2).
    function automatic logic [31:0] stub_word(input logic [19:0] target_hi, input logic second);
        if (second) begin
            return {12'h000, REG_X2, 3'b000, 5'd0, RV_OPC_JALR};
        end
        return {target_hi, REG_X2, RV_OPC_LUI};
    endfunction

endpackage

// File: rtl/rom_bus.sv
// Bus-attached read-only boot memory with 1- or 2-cycle read latency.
// Define ROM_BOOT_STUB_EN to replace the image with a jump stub.
module rom_bus
    import rom_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 512,
    parameter bit          OUT_REG     = 1'b0,
    parameter string       INIT_FILE   = "rom.mem",
    parameter logic [31:0] STUB_TARGET = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int ADDR_W = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

`ifdef ROM_BOOT_STUB_EN
    localparam logic [63:0] STUB_IMG = {stub_word(STUB_TARGET[31:12], 1'b1),
                                        stub_word(STUB_TARGET[31:12], 1'b0)};

    initial begin
        for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
            mem[ADDR_W'(i)] = 8'h00;
        end
        for (int k = 0; k < 8; k++) begin
            mem[ADDR_W'(k)] = STUB_IMG[8*k +: 8];
        end
    end
`endif

    assign gnt_o = 1'b1;

    err_cause_e cause;

    always_comb begin
        cause = ERR_NONE;
        if (we_i) begin
            cause = ERR_WRITE;
        end else if (addr_i[1:0] != 2'b00) begin
            cause = ERR_MISALIGN;
        end else if (addr_i >= 32'(DEPTH_BYTES)) begin
            cause = ERR_RANGE;
        end
    end

    // Out-of-range addresses alias here, but their data is masked to zero.
    logic [31:0] rd_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign rd_word[8*gi +: 8] = mem[{addr_i[ADDR_W-1:2], 2'(gi)}];
    end

    logic        s1_valid_reg;
    logic        s1_err_reg;
    logic [31:0] s1_data_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= req_i;
            s1_err_reg   <= req_i && (cause != ERR_NONE);
            if (req_i) begin
                s1_data_reg <= (cause == ERR_NONE) ? rd_word : 32'h0;
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic        s2_valid_reg;
        logic        s2_err_reg;
        logic [31:0] s2_data_reg;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s2_valid_reg <= 1'b0;
                s2_err_reg   <= 1'b0;
                s2_data_reg  <= '0;
            end else begin
                s2_valid_reg <= s1_valid_reg;
                s2_err_reg   <= s1_err_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= s1_data_reg;
                end
            end
        end

        assign rvalid_o = s2_valid_reg;
        assign err_o    = s2_err_reg;
        assign rdata_o  = s2_data_reg;
    end else begin : g_no_out_reg
        assign rvalid_o = s1_valid_reg;
        assign err_o    = s1_err_reg;
        assign rdata_o  = s1_data_reg;
    end

endmodule

// File: tb/tb_rom_bus.sv
// Directed bench for rom_bus: one instance per latency (OUT_REG=0 and 1)
// driven from shared request inputs, checked against hand-computed words.
module tb_rom_bus;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;

    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0;
    logic        gnt1, rvalid1, err1;
    logic [31:0] rdata1;

    int errors = 0;
    int checks = 0;

    rom_bus #(
        .DEPTH_BYTES(512),
        .OUT_REG    (1'b0),
        .INIT_FILE  (""),
        .STUB_TARGET(32'h0000_2000)
    ) dut0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .gnt_o   (gnt0),
        .rvalid_o(rvalid0),
        .rdata_o (rdata0),
        .err_o   (err0)
    );

    rom_bus #(
        .DEPTH_BYTES(512),
        .OUT_REG    (1'b1),
        .INIT_FILE  (""),
        .STUB_TARGET(32'h8000_0000)
    ) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .gnt_o   (gnt1),
        .rvalid_o(rvalid1),
        .rdata_o (rdata1),
        .err_o   (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Image: byte i = i[7:0] (default build) or the boot stub (stub build).
    function automatic logic [31:0] exp_word(input logic [31:0] a, input bit is_dut1);
`ifdef ROM_BOOT_STUB_EN
        if (a == 32'h0) return is_dut1 ? 32'h8000_0137 : 32'h0000_2137;
        if (a == 32'h4) return 32'h0001_0067;
        return 32'h0;
`else
        logic [7:0] b;
        b = a[7:0];
        if (is_dut1 && a[31]) return 32'h0;
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
`endif
    endfunction

    task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic exp_err);
        logic [31:0] e0;
        logic [31:0] e1;
        e0 = exp_err ? 32'h0 : exp_word(a, 1'b0);
        e1 = exp_err ? 32'h0 : exp_word(a, 1'b1);
        @(posedge clk);
        #1 req = 1'b1; we = w; addr = a;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0;
        @(negedge clk);
        check_eq({tag, "/gnt"}, {31'h0, gnt0 & gnt1}, 32'h1);
        check_eq({tag, "/rvalid0"}, {31'h0, rvalid0}, 32'h1);
        check_eq({tag, "/err0"}, {31'h0, err0}, {31'h0, exp_err});
        check_eq({tag, "/rdata0"}, rdata0, e0);
        check_eq({tag, "/rvalid1_early"}, {31'h0, rvalid1}, 32'h0);
        @(negedge clk);
        check_eq({tag, "/rvalid1"}, {31'h0, rvalid1}, 32'h1);
        check_eq({tag, "/err1"}, {31'h0, err1}, {31'h0, exp_err});
        check_eq({tag, "/rdata1"}, rdata1, e1);
        check_eq({tag, "/rvalid0_idle"}, {31'h0, rvalid0}, 32'h0);
        check_eq({tag, "/err0_idle"}, {31'h0, err0}, 32'h0);
        check_eq({tag, "/rdata0_hold"}, rdata0, e0);
        $display("xfer %s we=%0d addr=%h -> d0=%h e0=%0d d1=%h e1=%0d",
                 tag, w, a, rdata0, err0, rdata1, err1);
    endtask

    initial begin
        rst  = 1'b0;
        req  = 1'b0;
        we   = 1'b0;
        addr = 32'h0;
`ifndef ROM_BOOT_STUB_EN
        for (int i = 0; i < 512; i++) begin
            dut0.mem[9'(i)] = 8'(i);
            dut1.mem[9'(i)] = 8'(i);
        end
`endif
        #2 rst = 1'b1;
        #1;
        check_eq("reset/rvalid0", {31'h0, rvalid0}, 32'h0);
        check_eq("reset/err0", {31'h0, err0}, 32'h0);
        check_eq("reset/rdata0", rdata0, 32'h0);
        check_eq("reset/rvalid1", {31'h0, rvalid1}, 32'h0);
        check_eq("reset/err1", {31'h0, err1}, 32'h0);
        check_eq("reset/rdata1", rdata1, 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;

        xfer("rd_0x10", 1'b0, 32'h10, 1'b0);
        xfer("rd_0x0", 1'b0, 32'h0, 1'b0);
        xfer("rd_0x4", 1'b0, 32'h4, 1'b0);
        xfer("rd_0x8", 1'b0, 32'h8, 1'b0);
        xfer("wr_0x0", 1'b1, 32'h0, 1'b1);
        xfer("rd_0x0_after_wr", 1'b0, 32'h0, 1'b0);
        xfer("rd_0x2", 1'b0, 32'h2, 1'b1);
        xfer("rd_0x200", 1'b0, 32'h200, 1'b1);
        xfer("rd_0x1fc", 1'b0, 32'h1FC, 1'b0);
        xfer("rd_0x10_again", 1'b0, 32'h10, 1'b0);

        // Back-to-back reads at 0x0..0xC; dut0 answers one cycle after each
        // accept edge, dut1 two cycles after.
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(posedge clk);
            #1;
            req  = (cyc < 4);
            addr = 32'(cyc * 4);
            @(negedge clk);
            if (cyc >= 1 && cyc <= 4) begin
                check_eq($sformatf("burst/rvalid0_%0d", cyc), {31'h0, rvalid0}, 32'h1);
                check_eq($sformatf("burst/rdata0_%0d", cyc), rdata0, exp_word(32'((cyc - 1) * 4), 1'b0));
            end else begin
                check_eq($sformatf("burst/rvalid0_%0d", cyc), {31'h0, rvalid0}, 32'h0);
            end
            if (cyc >= 2 && cyc <= 5) begin
                check_eq($sformatf("burst/rvalid1_%0d", cyc), {31'h0, rvalid1}, 32'h1);
                check_eq($sformatf("burst/err1_%0d", cyc), {31'h0, err1}, 32'h0);
                check_eq($sformatf("burst/rdata1_%0d", cyc), rdata1, exp_word(32'((cyc - 2) * 4), 1'b1));
            end else begin
                check_eq($sformatf("burst/rvalid1_%0d", cyc), {31'h0, rvalid1}, 32'h0);
            end
            $display("burst cycle %0d: v0=%0d d0=%h v1=%0d d1=%h", cyc, rvalid0, rdata0, rvalid1, rdata1);
        end
        req = 1'b0;

        // Two requests in flight, then an asynchronous mid-cycle reset.
        @(posedge clk);
        #1 req = 1'b1; addr = 32'h10;
        @(posedge clk);
        #1 addr = 32'h14;
        @(posedge clk);
        #1 req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst/rvalid0", {31'h0, rvalid0}, 32'h0);
        check_eq("midrst/rdata0", rdata0, 32'h0);
        check_eq("midrst/err0", {31'h0, err0}, 32'h0);
        check_eq("midrst/rvalid1", {31'h0, rvalid1}, 32'h0);
        check_eq("midrst/rdata1", rdata1, 32'h0);
        check_eq("midrst/err1", {31'h0, err1}, 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check_eq($sformatf("postrst/rvalid0_%0d", cyc), {31'h0, rvalid0}, 32'h0);
            check_eq($sformatf("postrst/rvalid1_%0d", cyc), {31'h0, rvalid1}, 32'h0);
        end
        $display("reset mid-flight: outputs cleared, no stale responses");
        xfer("rd_0x0_postrst", 1'b0, 32'h0, 1'b0);
        xfer("rd_0xc_postrst", 1'b0, 32'hC, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
